// File: rtl/intr_timer_gen.sv
// Memory-mapped 64-bit mtime/mtimecmp timer plus synchronised external IRQ,
// issuing single-cycle t_intr/e_intr pulses that re-arm only on MRET.
module intr_timer_gen #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        tmr_wr,
    input  logic        tmr_rd,
    output logic [31:0] rdata,
    input  logic        ext_irq_i,
    input  logic        is_mret,
    output logic        t_intr,
    output logic        e_intr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] T_SVC = 2'd1;
    localparam logic [1:0] E_SVC = 2'd2;

    localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [1:0]    ctrl;
    logic [PW-1:0] pre_cnt;
    logic          s1, s2, s3;
    logic          match_d;
    logic          timer_pend;
    logic          ext_pend;
    logic [1:0]    state;

    logic [31:0] off;
    logic        wr_tlo, wr_thi, wr_clo, wr_chi, wr_ctrl;
    logic        tmr_en, ext_en;
    logic        tick, match;
    logic        timer_rise, ext_rise;
    logic        timer_take, ext_take;

    always_comb begin
        off     = addr - BASE_ADDR;
        wr_tlo  = tmr_wr && (off == 32'h00);
        wr_thi  = tmr_wr && (off == 32'h04);
        wr_clo  = tmr_wr && (off == 32'h08);
        wr_chi  = tmr_wr && (off == 32'h0C);
        wr_ctrl = tmr_wr && (off == 32'h10);

        rdata = '0;
        if (tmr_rd) begin
            case (off)
                32'h00:  rdata = mtime[31:0];
                32'h04:  rdata = mtime[63:32];
                32'h08:  rdata = mtimecmp[31:0];
                32'h0C:  rdata = mtimecmp[63:32];
                32'h10:  rdata = {30'b0, ctrl};
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        tmr_en     = ctrl[0];
        ext_en     = ctrl[1];
        tick       = tmr_en && (pre_cnt == PRE_LAST);
        match      = tmr_en && (mtime >= mtimecmp);
        timer_rise = match && !match_d;
        ext_rise   = ext_en && s2 && !s3;
        timer_take = (state == IDLE) && timer_pend;
        ext_take   = (state == IDLE) && !timer_pend && ext_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime      <= '0;
            mtimecmp   <= '1;
            ctrl       <= '0;
            pre_cnt    <= '0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            match_d    <= 1'b0;
            timer_pend <= 1'b0;
            ext_pend   <= 1'b0;
            state      <= IDLE;
            t_intr     <= 1'b0;
            e_intr     <= 1'b0;
        end else begin
            if (tmr_en)
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

            // A software write to either mtime half suppresses that cycle's increment.
            if (wr_tlo)
                mtime[31:0] <= wdata;
            if (wr_thi)
                mtime[63:32] <= wdata;
            if (!wr_tlo && !wr_thi && tick)
                mtime <= mtime + 64'd1;

            if (wr_clo)
                mtimecmp[31:0] <= wdata;
            if (wr_chi)
                mtimecmp[63:32] <= wdata;
            if (wr_ctrl)
                ctrl <= wdata[1:0];

            s1 <= ext_irq_i;
            s2 <= s1;
            s3 <= s2;
            match_d <= match;

            timer_pend <= (timer_pend && !timer_take) || timer_rise;
            ext_pend   <= (ext_pend && !ext_take) || ext_rise;

            t_intr <= timer_take;
            e_intr <= ext_take;

            case (state)
                IDLE: begin
                    if (timer_take)
                        state <= T_SVC;
                    else if (ext_take)
                        state <= E_SVC;
                end
                T_SVC, E_SVC: begin
                    if (is_mret)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_timer_gen.sv
// Directed bench for intr_timer_gen: register reads checked inline, interrupt
// pulses checked against a queue of expected (cycle, kind) entries.
module tb_intr_timer_gen;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_TLO  = BASE + 32'h00;
    localparam logic [31:0] A_THI  = BASE + 32'h04;
    localparam logic [31:0] A_CLO  = BASE + 32'h08;
    localparam logic [31:0] A_CHI  = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = BASE + 32'h10;
    localparam logic [31:0] A_NONE = BASE + 32'h14;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        tmr_wr;
    logic        tmr_rd;
    logic [31:0] rdata;
    logic        ext_irq_i;
    logic        is_mret;
    logic        t_intr;
    logic        e_intr;

    intr_timer_gen #(
        .BASE_ADDR(BASE),
        .PRESCALE (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .tmr_wr   (tmr_wr),
        .tmr_rd   (tmr_rd),
        .rdata    (rdata),
        .ext_irq_i(ext_irq_i),
        .is_mret  (is_mret),
        .t_intr   (t_intr),
        .e_intr   (e_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_t;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   tests;
    int   fails;
    int   c0;
    int   m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int c, input bit is_t);
        exp_t e;
        e.cyc  = c;
        e.is_t = is_t;
        exp_q.push_back(e);
    endtask

    // Advance one clock and score any interrupt pulse seen in the new cycle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("never_both", {63'b0, t_intr & e_intr}, 64'd0);
        if (t_intr || e_intr) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", {63'b0, t_intr | e_intr}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                chk("pulse_kind_t", {63'b0, t_intr}, {63'b0, e.is_t});
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missed_pulse", {63'b0, t_intr | e_intr}, 64'd1);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wdata  = d;
        tmr_wr = 1'b1;
        step();
        tmr_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr   = a;
        tmr_rd = 1'b1;
        #1;
        chk(tag, {32'b0, rdata}, {32'b0, exp});
        tmr_rd = 1'b0;
    endtask

    task automatic mret();
        is_mret = 1'b1;
        step();
        is_mret = 1'b0;
    endtask

    initial begin
        cyc = 0; tests = 0; fails = 0;
        rst = 1'b1; addr = '0; wdata = '0; tmr_wr = 1'b0; tmr_rd = 1'b0;
        ext_irq_i = 1'b0; is_mret = 1'b0;

        // 1: reset values
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_t_intr", {63'b0, t_intr}, 64'd0);
        chk("rst_e_intr", {63'b0, e_intr}, 64'd0);
        rd("rst_mtime_lo", A_TLO, 32'h0);
        rd("rst_mtime_hi", A_THI, 32'h0);
        rd("rst_cmp_lo", A_CLO, 32'hFFFF_FFFF);
        rd("rst_cmp_hi", A_CHI, 32'hFFFF_FFFF);
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("unmapped_0x14", A_NONE, 32'h0);
        addr = A_CLO;
        #1;
        chk("rdata_no_strobe", {32'b0, rdata}, 64'd0);

        // 2: count to mtimecmp=10, single timer pulse
        wr(A_CLO, 32'd10);
        wr(A_CHI, 32'd0);
        rd("cmp_lo_written", A_CLO, 32'd10);
        wr(A_CTRL, 32'd1);
        c0 = cyc;
        expect_pulse(c0 + 12, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            rd("mtime_count", A_TLO, 32'(k));
            step();
        end
        repeat (12) step();
        wr(A_CTRL, 32'd2);
        mret();
        repeat (2) step();

        // 3: external pulse, second edge during E_SVC waits for mret
        ext_irq_i = 1'b1;
        expect_pulse(cyc + 4, 1'b0);
        repeat (5) step();
        ext_irq_i = 1'b0;
        repeat (3) step();
        ext_irq_i = 1'b1;
        repeat (2) step();
        ext_irq_i = 1'b0;
        repeat (6) step();
        is_mret = 1'b1;
        expect_pulse(cyc + 2, 1'b0);
        step();
        is_mret = 1'b0;
        repeat (3) step();
        mret();
        step();

        // 4: timer and external pending together -> timer first
        wr(A_TLO, 32'd0);
        wr(A_THI, 32'd0);
        wr(A_CLO, 32'd5);
        wr(A_CTRL, 32'd3);
        c0 = cyc;
        expect_pulse(c0 + 7, 1'b1);
        repeat (3) step();
        ext_irq_i = 1'b1;
        repeat (2) step();
        ext_irq_i = 1'b0;
        repeat (5) step();
        is_mret = 1'b1;
        expect_pulse(cyc + 2, 1'b0);
        step();
        is_mret = 1'b0;
        repeat (4) step();
        mret();
        repeat (3) step();

        // 5: 64-bit wrap, match falls and re-rises; write beats tick
        wr(A_CTRL, 32'd0);
        wr(A_THI, 32'hFFFF_FFFF);
        wr(A_TLO, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'd1);
        c0 = cyc;
        expect_pulse(c0 + 2, 1'b1);
        rd("wrap_hi_pre", A_THI, 32'hFFFF_FFFF);
        rd("wrap_lo_pre", A_TLO, 32'hFFFF_FFFE);
        step();
        rd("wrap_lo_max", A_TLO, 32'hFFFF_FFFF);
        step();
        rd("wrap_lo_zero", A_TLO, 32'h0);
        rd("wrap_hi_zero", A_THI, 32'h0);
        mret();
        expect_pulse(c0 + 9, 1'b1);
        repeat (7) step();
        wr(A_TLO, 32'h1234_0000);
        rd("wr_beats_tick_lo", A_TLO, 32'h1234_0000);
        rd("wr_beats_tick_hi", A_THI, 32'h0);
        step();
        rd("tick_after_wr", A_TLO, 32'h1234_0001);

        // 6: reset while in T_SVC with an external request pending
        wr(A_CTRL, 32'd3);
        ext_irq_i = 1'b1;
        repeat (5) step();
        ext_irq_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_t_intr", {63'b0, t_intr}, 64'd0);
        chk("rst2_e_intr", {63'b0, e_intr}, 64'd0);
        rd("rst2_mtime_lo", A_TLO, 32'h0);
        rd("rst2_mtime_hi", A_THI, 32'h0);
        rd("rst2_cmp_lo", A_CLO, 32'hFFFF_FFFF);
        rd("rst2_cmp_hi", A_CHI, 32'hFFFF_FFFF);
        rd("rst2_ctrl", A_CTRL, 32'h0);
        repeat (10) step();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
